// File: rtl/bram_read_stream_adapter.sv
// Ready/valid front end for a fixed-latency block RAM read port.
// Credit-tracked issue, valid pipe, and a bypassing response FIFO.
module bram_read_stream_adapter #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 9,
    parameter int READ_LATENCY = 2,
    parameter int BUFFER_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  rsp_ready,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    output logic                  ram_enb,
    output logic                  ram_regceb,
    input  logic [DATA_WIDTH-1:0] ram_doutb
);

    localparam int OW = $clog2(BUFFER_DEPTH + 1);
    localparam int PW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam logic [OW-1:0] DEPTH_C = OW'(BUFFER_DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(BUFFER_DEPTH - 1);

    logic [OW-1:0]           r_occ;
    logic [OW-1:0]           r_cnt;
    logic [PW-1:0]           r_rd;
    logic [PW-1:0]           r_wr;
    logic [READ_LATENCY-1:0] r_vpipe;
    logic [DATA_WIDTH-1:0]   r_mem [BUFFER_DEPTH];

    logic w_issue;
    logic w_pop;
    logic w_arrive;
    logic w_empty;
    logic w_write;
    logic w_fifo_pop;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + PW'(1);
    endfunction

    // Credits come only from registered state, so req_ready never
    // looks at req_valid and a pop frees its credit one cycle later.
    assign req_ready  = (r_occ < DEPTH_C);
    assign w_issue    = req_valid & req_ready;
    assign ram_enb    = w_issue;
    assign ram_addrb  = req_addr;
    assign ram_regceb = r_vpipe[0];
    assign w_arrive   = r_vpipe[READ_LATENCY-1];

    // Empty FIFO lets the arriving RAM word pass straight through.
    assign w_empty    = (r_cnt == '0);
    assign rsp_valid  = ~w_empty | w_arrive;
    assign rsp_data   = w_empty ? ram_doutb : r_mem[r_rd];
    assign w_pop      = rsp_valid & rsp_ready;
    assign w_write    = w_arrive & ~(w_empty & rsp_ready);
    assign w_fifo_pop = w_pop & ~w_empty;

    // Outstanding-read counter: issued but not yet consumed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_occ <= '0;
        end else if (w_issue & ~w_pop) begin
            r_occ <= r_occ + OW'(1);
        end else if (~w_issue & w_pop) begin
            r_occ <= r_occ - OW'(1);
        end
    end

    generate
        if (READ_LATENCY > 1) begin : g_pipe
            // Valid shift register mirroring the RAM read pipeline.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_vpipe <= '0;
                end else begin
                    r_vpipe <= {r_vpipe[READ_LATENCY-2:0], w_issue};
                end
            end
        end else begin : g_pipe1
            // Single-stage valid tracker for the low-latency RAM mode.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_vpipe <= '0;
                end else begin
                    r_vpipe <= w_issue;
                end
            end
        end
    endgenerate

    // FIFO pointers and fill count; pop and write may coincide.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_write) begin
                r_wr <= f_next(r_wr);
            end
            if (w_fifo_pop) begin
                r_rd <= f_next(r_rd);
            end
            if (w_write & ~w_fifo_pop) begin
                r_cnt <= r_cnt + OW'(1);
            end else if (~w_write & w_fifo_pop) begin
                r_cnt <= r_cnt - OW'(1);
            end
        end
    end

    // FIFO storage; contents need no reset since the count gates them.
    always_ff @(posedge clock) begin
        if (w_write) begin
            r_mem[r_wr] <= ram_doutb;
        end
    end

endmodule

// File: tb/tb_bram_read_stream_adapter.sv
// Scoreboard bench for bram_read_stream_adapter: L=2/D=4 and L=1/D=1
// instances, each paired with a behavioural block RAM read port.
module tb_bram_read_stream_adapter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [63:0] mem [512];
    logic [63:0] qa [$];
    logic [63:0] qb [$];

    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
    logic [8:0]  a_req_addr, a_addrb;
    logic        a_enb, a_regceb;
    logic [63:0] a_rsp_data, a_doutb, a_lat;

    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [8:0]  b_req_addr, b_addrb;
    logic        b_enb, b_regceb;
    logic [63:0] b_rsp_data, b_doutb;

    bram_read_stream_adapter #(
        .DATA_WIDTH(64), .ADDR_WIDTH(9), .READ_LATENCY(2), .BUFFER_DEPTH(4)
    ) dut_a (
        .clock(clock), .reset(reset),
        .req_valid(a_req_valid), .req_addr(a_req_addr), .req_ready(a_req_ready),
        .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_ready(a_rsp_ready),
        .ram_addrb(a_addrb), .ram_enb(a_enb), .ram_regceb(a_regceb),
        .ram_doutb(a_doutb)
    );

    bram_read_stream_adapter #(
        .DATA_WIDTH(64), .ADDR_WIDTH(9), .READ_LATENCY(1), .BUFFER_DEPTH(1)
    ) dut_b (
        .clock(clock), .reset(reset),
        .req_valid(b_req_valid), .req_addr(b_req_addr), .req_ready(b_req_ready),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_ready(b_rsp_ready),
        .ram_addrb(b_addrb), .ram_enb(b_enb), .ram_regceb(b_regceb),
        .ram_doutb(b_doutb)
    );

    // RAM models: HIGH_PERFORMANCE (latch + output register) and LOW_LATENCY.
    initial begin
        a_lat   = '0;
        a_doutb = '0;
        b_doutb = '0;
        for (int i = 0; i < 512; i++) mem[i] = 64'h5A5A_0000_0000_0000 | 64'(i);
        mem[5] = 64'hAB;
    end
    always @(posedge clock) begin
        if (a_enb) a_lat <= mem[a_addrb];
        if (a_regceb) a_doutb <= a_lat;
        if (b_enb) b_doutb <= mem[b_addrb];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: push on issue, pop and compare on every accepted response.
    always @(negedge clock) begin
        if (!reset) begin
            if (a_req_valid && a_req_ready) qa.push_back(mem[a_req_addr]);
            if (b_req_valid && b_req_ready) qb.push_back(mem[b_req_addr]);
            if (a_rsp_valid && a_rsp_ready) begin
                if (qa.size() == 0) begin
                    total++; bad++;
                    $display("FAIL a_unexpected: got %0h expected none", a_rsp_data);
                end else begin
                    chk("a_rsp_data", a_rsp_data, qa.pop_front());
                end
            end
            if (b_rsp_valid && b_rsp_ready) begin
                if (qb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL b_unexpected: got %0h expected none", b_rsp_data);
                end else begin
                    chk("b_rsp_data", b_rsp_data, qb.pop_front());
                end
            end
            chk("a_no_overflow", 64'(dut_a.w_arrive && dut_a.r_cnt == 3'd4), 0);
        end
    end

    initial begin
        int n;
        a_req_valid = 0; a_req_addr = '0; a_rsp_ready = 1;
        b_req_valid = 0; b_req_addr = '0; b_rsp_ready = 1;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_req_ready", 64'(a_req_ready), 1);
        chk("rst_rsp_valid", 64'(a_rsp_valid), 0);
        chk("rst_enb", 64'(a_enb), 0);
        chk("rst_regceb", 64'(a_regceb), 0);
        chk("rst_b_req_ready", 64'(b_req_ready), 1);
        step();
        reset = 0;
        step();

        // Single read of address 5
        a_req_valid = 1; a_req_addr = 9'd5;
        @(negedge clock);
        chk("single_enb", 64'(a_enb), 1);
        chk("single_addrb", 64'(a_addrb), 5);
        chk("single_v0", 64'(a_rsp_valid), 0);
        step();
        a_req_valid = 0;
        @(negedge clock);
        chk("single_regceb", 64'(a_regceb), 1);
        chk("single_v1", 64'(a_rsp_valid), 0);
        step();
        @(negedge clock);
        chk("single_v2", 64'(a_rsp_valid), 1);
        chk("single_data", a_rsp_data, 64'hAB);
        step();
        @(negedge clock);
        chk("single_v3", 64'(a_rsp_valid), 0);
        step();

        // Streaming 0..15 back to back
        for (int k = 0; k < 20; k++) begin
            a_req_valid = (k < 16);
            a_req_addr  = 9'(k);
            @(negedge clock);
            if (k < 16) chk("stream_req_ready", 64'(a_req_ready), 1);
            chk("stream_rsp_valid", 64'(a_rsp_valid), 64'(k >= 2 && k <= 17));
            step();
        end

        // Backpressure: exactly four issues, head word stable
        a_rsp_ready = 0;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            a_req_valid = 1;
            a_req_addr  = 9'(32 + k);
            @(negedge clock);
            if (a_req_valid && a_req_ready) n++;
            chk("bp_req_ready", 64'(a_req_ready), 64'(k < 4));
            chk("bp_rsp_valid", 64'(a_rsp_valid), 64'(k >= 2));
            if (k >= 2) chk("bp_head", a_rsp_data, mem[32]);
            step();
        end
        chk("bp_issues", 64'(n), 4);
        a_req_valid = 0;
        for (int j = 0; j < 5; j++) begin
            a_rsp_ready = 1;
            @(negedge clock);
            chk("drain_rsp_valid", 64'(a_rsp_valid), 64'(j < 4));
            chk("drain_req_ready", 64'(a_req_ready), 64'(j >= 1));
            step();
        end

        // Full occupancy with pop and arrival in the same cycle
        for (int k = 0; k < 12; k++) begin
            a_req_valid = (k < 4);
            a_req_addr  = 9'(40 + k);
            a_rsp_ready = (k == 5 || k >= 7);
            @(negedge clock);
            if (k == 5) begin
                chk("full_cnt5", 64'(dut_a.r_cnt), 3);
                chk("full_occ5", 64'(dut_a.r_occ), 4);
                chk("full_arrive5", 64'(dut_a.w_arrive), 1);
                chk("full_head5", a_rsp_data, mem[40]);
            end
            if (k == 6) begin
                chk("full_cnt6", 64'(dut_a.r_cnt), 3);
                chk("full_occ6", 64'(dut_a.r_occ), 3);
                chk("full_head6", a_rsp_data, mem[41]);
            end
            if (k == 11) chk("full_done_valid", 64'(a_rsp_valid), 0);
            step();
        end

        // Reset with two reads in flight and one buffered
        a_rsp_ready = 0;
        for (int k = 0; k < 4; k++) begin
            a_req_valid = (k < 3);
            a_req_addr  = 9'(50 + k);
            @(negedge clock);
            if (k < 3) step();
        end
        chk("mid_cnt", 64'(dut_a.r_cnt), 1);
        chk("mid_vpipe", 64'(dut_a.r_vpipe), 3);
        reset = 1;
        qa.delete();
        #1;
        chk("mid_rst_rsp_valid", 64'(a_rsp_valid), 0);
        chk("mid_rst_req_ready", 64'(a_req_ready), 1);
        chk("mid_rst_regceb", 64'(a_regceb), 0);
        step();
        step();
        reset = 0;
        a_rsp_ready = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("post_rst_no_stale", 64'(a_rsp_valid), 0);
            step();
        end
        for (int k = 0; k < 4; k++) begin
            a_req_valid = (k == 0);
            a_req_addr  = 9'd7;
            @(negedge clock);
            chk("post_rst_valid", 64'(a_rsp_valid), 64'(k == 2));
            if (k == 2) chk("post_rst_data", a_rsp_data, mem[7]);
            step();
        end

        // L=1, depth 1: one outstanding read, latency one
        for (int k = 0; k < 10; k++) begin
            b_req_valid = 1;
            b_req_addr  = 9'(100 + k / 2);
            @(negedge clock);
            chk("b_req_ready", 64'(b_req_ready), 64'(k % 2 == 0));
            chk("b_rsp_valid", 64'(b_rsp_valid), 64'(k % 2 == 1));
            chk("b_outstanding", 64'(dut_b.r_occ <= 1), 1);
            if (k % 2 == 1) chk("b_data_direct", b_rsp_data, mem[100 + k / 2]);
            step();
        end
        b_req_valid = 0;
        repeat (3) step();

        chk("a_queue_empty", 64'(qa.size()), 0);
        chk("b_queue_empty", 64'(qb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
